// File: rtl/bitty_pkg.sv
// Shared types and instruction field positions for the BittyPro write-back stage.
package bitty_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int RX_MSB   = 15;
  localparam int RX_LSB   = 13;
  localparam int RY_MSB   = 12;
  localparam int RY_LSB   = 10;
  localparam int SEL_MSB  = 5;
  localparam int SEL_LSB  = 2;
  localparam int NUM_REGS = 8;

endpackage

// File: rtl/bitty_regfile.sv
// Eight-entry register file, single synchronous write port, sync active-low reset.
// Write visible the cycle after the write edge; no backpressure (always accepts a write).
module bitty_regfile
  import bitty_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             we_i,
  input  logic [2:0]                       waddr_i,
  input  logic [DATA_W-1:0]                wdata_i,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/bitty_writeback.sv
// BittyPro write-back stage: accept -> EXEC (capture ALU) -> WRITE (Rx update, done pulse), 3 cycles/instr.
// inst_ready is low while busy or while a direct load is requested; flags built only with BITTY_FLAGS_EN.
module bitty_writeback
  import bitty_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inst_valid,
  input  logic [15:0]       inst_in,
  output logic              inst_ready,
  output logic [15:0]       inst_q,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  input  logic              alu_comp,
  input  logic              load_en,
  input  logic [2:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done
);

  state_t                          state_q, state_d;
  logic [15:0]                     inst_d, inst_reg_q;
  logic [DATA_W-1:0]               result_q, result_d;
  logic                            done_q, done_d;
  logic                            rf_we;
  logic [2:0]                      rf_waddr;
  logic [DATA_W-1:0]               rf_wdata;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      inst_reg_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_reg_q <= inst_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_reg_q;
    result_d   = result_q;
    done_d     = 1'b0;
    inst_ready = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = load_addr;
    rf_wdata   = load_data;
    case (state_q)
      IDLE: begin
        inst_ready = !load_en;
        // A direct load wins the cycle; the offered instruction waits.
        if (load_en) begin
          rf_we = 1'b1;
        end else if (inst_valid) begin
          inst_d  = inst_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        state_d  = WRITE;
      end
      WRITE: begin
        rf_we    = 1'b1;
        rf_waddr = inst_reg_q[RX_MSB:RX_LSB];
        rf_wdata = result_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  bitty_regfile #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .regs_o  (regs)
  );

`ifdef BITTY_FLAGS_EN
  logic flag_c_q, flag_z_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (state_q == EXEC) begin
      flag_c_q <= alu_cout;
      flag_z_q <= alu_comp;
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`else
  logic unused_flags;
  assign unused_flags = alu_cout ^ alu_comp;
  assign flag_c       = 1'b0;
  assign flag_z       = 1'b0;
`endif

  assign inst_q = inst_reg_q;
  assign done   = done_q;
  assign reg0   = regs[0];
  assign reg1   = regs[1];
  assign reg2   = regs[2];
  assign reg3   = regs[3];
  assign reg4   = regs[4];
  assign reg5   = regs[5];
  assign reg6   = regs[6];
  assign reg7   = regs[7];

endmodule

// File: tb/tb_bitty_writeback.sv
// Directed plus randomized bench for bitty_writeback against a transaction-level register-file model.
module tb_bitty_writeback;

  logic        clk = 1'b0;
  logic        reset_n, inst_valid, load_en, alu_cout, alu_comp;
  logic [15:0] inst_in, alu_out, load_data;
  logic [2:0]  load_addr;
  logic        inst_ready, done, flag_c, flag_z;
  logic [15:0] inst_q;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [15:0] dut_regs [8];

  always #5 clk = ~clk;

  bitty_writeback #(.DATA_W(16), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .inst_in(inst_in),
    .inst_ready(inst_ready), .inst_q(inst_q), .alu_out(alu_out), .alu_cout(alu_cout),
    .alu_comp(alu_comp), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
    .reg6(reg6), .reg7(reg7), .flag_c(flag_c), .flag_z(flag_z), .done(done)
  );

  assign dut_regs[0] = reg0;
  assign dut_regs[1] = reg1;
  assign dut_regs[2] = reg2;
  assign dut_regs[3] = reg3;
  assign dut_regs[4] = reg4;
  assign dut_regs[5] = reg5;
  assign dut_regs[6] = reg6;
  assign dut_regs[7] = reg7;

`ifdef BITTY_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: register contents plus one instruction in flight, counted in remaining edges.
  logic [15:0] m_regs [8];
  int          m_busy = 0;
  logic [15:0] m_inst = '0;
  logic [15:0] m_res  = '0;
  logic        m_done = 1'b0;
  logic        m_fc   = 1'b0;
  logic        m_fz   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (!reset_n) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0000;
      m_busy = 0; m_inst = '0; m_res = '0; m_fc = 1'b0; m_fz = 1'b0;
    end else if (m_busy == 2) begin
      m_res = alu_out;
      if (FLAGS_ON) begin
        m_fc = alu_cout;
        m_fz = alu_comp;
      end
      m_busy = 1;
    end else if (m_busy == 1) begin
      m_regs[m_inst[15:13]] = m_res;
      m_done = 1'b1;
      m_busy = 0;
    end else if (load_en) begin
      m_regs[load_addr] = load_data;
    end else if (inst_valid) begin
      m_inst = inst_in;
      m_busy = 2;
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; checks happen before and after the next one.
  task automatic cycle();
    #1;
    if (reset_n) chk("inst_ready", inst_ready, (m_busy == 0) && !load_en);
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), dut_regs[i], m_regs[i]);
    chk("done", done, m_done);
    chk("inst_q", inst_q, m_inst);
    chk("flag_c", flag_c, m_fc);
    chk("flag_z", flag_z, m_fz);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pat [6];
    logic        pat_exp [6];
    logic [15:0] hold;
    logic [15:0] r1_before;

    foreach (m_regs[i]) m_regs[i] = 16'h0000;
    pat_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held 2 cycles with load and valid both asserted.
    reset_n = 1'b0; load_en = 1'b1; inst_valid = 1'b1; inst_in = 16'hFFFF;
    load_addr = 3'd0; load_data = 16'h1234; alu_out = 16'h0; alu_cout = 1'b0; alu_comp = 1'b0;
    @(posedge clk); #1;
    cycle();
    cycle();
    for (int i = 0; i < 8; i++) chk("rst_reg", dut_regs[i], 16'h0000);
    chk("rst_done", done, 1'b0);
    chk("rst_inst_q", inst_q, 16'h0000);
    reset_n = 1'b1; load_en = 1'b0; inst_valid = 1'b0;
    #1 chk("rst_ready", inst_ready, 1'b1);

    // Load reg3 then write it back through an instruction.
    load_en = 1'b1; load_addr = 3'd3; load_data = 16'h0005;
    cycle();
    load_en = 1'b0;
    chk("load_reg3", reg3, 16'h0005);
    inst_valid = 1'b1; inst_in = 16'h6000;
    cycle();
    inst_valid = 1'b0; alu_out = 16'h000A;
    chk("wb_inst_q", inst_q, 16'h6000);
    chk("wb_ready_exec", inst_ready, 1'b0);
    cycle();
    alu_out = 16'h3C3C;
    chk("wb_reg3_old", reg3, 16'h0005);
    chk("wb_done_early", done, 1'b0);
    cycle();
    chk("wb_done", done, 1'b1);
    chk("wb_reg3_new", reg3, 16'h000A);
    chk("wb_ready_done", inst_ready, 1'b1);
    cycle();
    chk("wb_done_pulse", done, 1'b0);

    // Continuous valid: ready pattern and inst_q stability while busy.
    inst_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inst_in = 16'($urandom); alu_out = 16'($urandom);
      #1 pat[i] = inst_ready;
      hold = inst_q;
      cycle();
      if (i % 3 != 0) chk("hs_inst_hold", inst_q, hold);
    end
    inst_valid = 1'b0;
    for (int i = 0; i < 6; i++) chk($sformatf("hs_ready%0d", i), pat[i], pat_exp[i]);

    // Load and instruction together: load wins, instruction taken next cycle.
    load_en = 1'b1; inst_valid = 1'b1; load_addr = 3'd5; load_data = 16'hBEEF; inst_in = 16'hA000;
    #1 chk("coll_ready", inst_ready, 1'b0);
    cycle();
    chk("coll_reg5", reg5, 16'hBEEF);
    load_en = 1'b0;
    #1 chk("coll_ready_next", inst_ready, 1'b1);
    cycle();
    chk("coll_accept", inst_q, 16'hA000);
    inst_valid = 1'b0; load_en = 1'b1; load_addr = 3'd1; load_data = 16'h1111; alu_out = 16'h0042;
    r1_before = reg1;
    cycle();
    cycle();
    load_en = 1'b0;
    chk("busy_load_ignored", reg1, r1_before);
    chk("coll_reg5_wb", reg5, 16'h0042);

    // Flags captured at EXEC and held through IDLE.
    inst_valid = 1'b1; inst_in = 16'h2000;
    cycle();
    inst_valid = 1'b0; alu_cout = 1'b1; alu_comp = 1'b1;
    cycle();
    alu_cout = 1'b0; alu_comp = 1'b0;
    chk("flag_c_set", flag_c, FLAGS_ON);
    chk("flag_z_set", flag_z, FLAGS_ON);
    cycle();
    cycle();
    chk("flag_c_hold", flag_c, FLAGS_ON);
    chk("flag_z_hold", flag_z, FLAGS_ON);

    // Reset during WRITE cancels the pending reg7 update.
    inst_valid = 1'b1; inst_in = 16'hE000;
    cycle();
    inst_valid = 1'b0; alu_out = 16'hFFFF;
    cycle();
    reset_n = 1'b0;
    cycle();
    chk("midrst_reg7", reg7, 16'h0000);
    chk("midrst_done", done, 1'b0);
    reset_n = 1'b1;
    cycle();
    chk("midrst_done_after", done, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset_n    = ($urandom_range(0, 99) != 0);
      inst_valid = ($urandom_range(0, 9) < 7);
      load_en    = ($urandom_range(0, 3) == 0);
      load_addr  = 3'($urandom);
      load_data  = 16'($urandom);
      inst_in    = 16'($urandom);
      alu_out    = 16'($urandom);
      alu_cout   = 1'($urandom);
      alu_comp   = 1'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitty_writeback.md
Name: bitty_writeback

Overview:
- Sequential write-back stage and register file for the BittyPro datapath.
- Accepts one instruction per handshake and holds it stable so the combinational operand-select/ALU datapath can evaluate.
- Captures the ALU result one cycle later and writes it into destination register Rx.
- Drives reg0..reg7 back into the datapath, closing the execute/write-back loop.

Parameters:
- DATA_W, 16, register and ALU result width.
- RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- inst_valid  input  1  new instruction offered.
- inst_in  input  16  offered instruction; Rx = [15:13], Ry = [12:10], sel = [5:2].
- inst_ready  output  1  block can accept an instruction.
- inst_q  output  16  latched instruction, drives the datapath inst input.
- alu_out  input  DATA_W  datapath result for inst_q.
- alu_cout  input  1  datapath carry out.
- alu_comp  input  1  datapath compare flag.
- load_en  input  1  direct register load, honoured only in IDLE.
- load_addr  input  3  register index for load.
- load_data  input  DATA_W  load value.
- reg0 .. reg7  output  DATA_W each  register file contents.
- flag_c  output  1  captured carry.
- flag_z  output  1  captured compare.
- done  output  1  one-cycle pulse when a write-back completes.

Behaviour:
- Reset, sampled on a clk edge with reset_n = 0:
  - state = IDLE; reg0..reg7 = RESET_VAL.
  - inst_q = 0, result_q = 0, flag_c = 0, flag_z = 0, done = 0.
  - Reset overrides any operation in flight; no partial write occurs.
- FSM states: IDLE, EXEC, WRITE.
- IDLE:
  - inst_ready = !load_en.
  - If load_en = 1: reg[load_addr] <= load_data; stay in IDLE; inst_valid is ignored that cycle.
  - Else if inst_valid = 1: inst_q <= inst_in; go to EXEC.
- EXEC (one cycle): inst_q is stable, so the datapath output settles. At the edge, result_q <= alu_out, flags are updated, and state goes to WRITE.
- WRITE (one cycle): reg[inst_q[15:13]] <= result_q; done <= 1; go to IDLE.
- done is registered and high for exactly the cycle after the write edge. The new register value is visible in that same cycle.
- inst_ready is 0 in EXEC and WRITE. load_en is ignored outside IDLE.
- Latency: accept edge T0, capture edge T1, write edge T2, done high during T2..T3.
- Throughput: one instruction per 3 cycles.
- A new instruction can be accepted in the cycle done is high, because the state is already IDLE.
- inst_q holds its value after WRITE until the next accept.
- Destination may equal a source: operands are read before T1, so the old value is used.
- All 8 registers are writable, including reg0. Results are truncated to DATA_W.
- inst_in bits other than Rx are not interpreted here. They only pass through inst_q.

Optional Feature:
- Macro: BITTY_FLAGS_EN.
- Defined: at the EXEC edge, flag_c <= alu_cout and flag_z <= alu_comp. Flags hold their values until the next EXEC or reset.
- Not defined: flag_c and flag_z are constant 0, alu_cout and alu_comp are unused, and no flag flops are built.

Decomposition:
- Shared package bitty_pkg:
  - State enum {IDLE, EXEC, WRITE}.
  - Field constants RX_MSB = 15, RX_LSB = 13, RY_MSB = 12, RY_LSB = 10, SEL_MSB = 5, SEL_LSB = 2.
  - NUM_REGS = 8.
- Sub-module bitty_regfile:
  - 8 x DATA_W flops with one synchronous write port (we, waddr, wdata) and sync reset to RESET_VAL.
  - The FSM muxes between the load and write-back sources.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with load_en = 1 and inst_valid = 1 -> all regs 0, inst_ready = 1 after release, done = 0.
- Load then write-back: load reg3 = 16'h0005; offer inst_in = 16'h6000 (Rx = 3); bench drives alu_out = 16'h000A during EXEC -> reg3 = 16'h000A in the cycle done is high, exactly 3 cycles after accept.
- Handshake: inst_valid held high continuously -> inst_ready pattern 1,0,0,1,0,0. Instructions are accepted only when inst_ready = 1, and inst_q never changes during EXEC or WRITE.
- Collision: load_en = 1 and inst_valid = 1 together in IDLE -> load performed, inst_ready = 0, instruction accepted the next cycle. load_en asserted during EXEC -> no register change.
- Mid-op reset: deassert reset_n in WRITE with result_q = 16'hFFFF targeting reg7 -> reg7 = 0, done stays 0.
- Flags, with BITTY_FLAGS_EN: alu_cout = 1, alu_comp = 1 at EXEC -> both flags 1 and held through IDLE. Without the macro -> both flags stay 0.
